// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the fetch and load/store requesters, one transaction in flight.
// Optional abort-on-timeout is enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] starve_cnt;
  logic          idle;
  logic          fetch_wins;
  logic          timeout_hit;

  // Grants are gated by n_rst so nothing is accepted while reset is held.
  assign idle       = (state == IDLE) && n_rst;
  assign fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_LIM));
  assign if_gnt     = idle && fetch_wins;
  assign d_gnt      = idle && d_req && !fetch_wins;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_gnt) begin
            state      <= BUSY_I;
            starve_cnt <= '0;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '1;
          end else if (d_gnt) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            if (if_req && (starve_cnt != STARVE_LIM))
              starve_cnt <= starve_cnt + SW'(1);
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_I) begin
              if_rdata  <= mem_rdata;
              if_rvalid <= 1'b1;
            end else begin
              if (!mem_we)
                d_rdata <= mem_rdata;
              d_rvalid <= 1'b1;
            end
          end else if (timeout_hit) begin
            // Aborted transactions still answer the owner so it never waits forever.
            state   <= IDLE;
            mem_req <= 1'b0;
            if (state == BUSY_I)
              if_rvalid <= 1'b1;
            else
              d_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Fires in the BUSY cycle whose missing ack would bring the count to TIMEOUT.
  assign timeout_hit = (state != IDLE) && !mem_ack && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= timeout_hit;
      if (if_gnt || d_gnt)
        wait_cnt <= '0;
      else if ((state != IDLE) && !mem_ack)
        wait_cnt <= wait_cnt + TW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  // TIMEOUT is never negative, so this is a constant 0.
  assign err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle plus literal expectations.
// Timeout scenario is included when ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic              clk;
  logic              n_rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              err;

  int    checks   = 0;
  int    failures = 0;
  string grant_seq = "";

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dd, input logic [3:0] db,
                                input logic ma, input logic [31:0] md);
    step();
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_be = db;
    mem_ack = ma; mem_rdata = md;
  endtask

  // Reference model: one record for the transaction in flight, a contested-grant tally,
  // and the responses owed to each requester.
  bit          m_busy, m_own_d, m_we, m_rv_i, m_rv_d, m_err, exp_ig, exp_dg;
  logic [31:0] m_addr, m_wdata, m_rdata_i, m_rdata_d;
  logic [3:0]  m_be;
  int          m_contested, m_wait;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        m_busy = 0; m_own_d = 0; m_we = 0; m_rv_i = 0; m_rv_d = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_be = 0; m_rdata_i = 0; m_rdata_d = 0;
        m_contested = 0; m_wait = 0;
        check_output("rst_if_gnt", 32'(if_gnt), 0);
        check_output("rst_d_gnt", 32'(d_gnt), 0);
        check_output("rst_mem_req", 32'(mem_req), 0);
        check_output("rst_mem_we", 32'(mem_we), 0);
        check_output("rst_mem_addr", mem_addr, 0);
        check_output("rst_mem_wdata", mem_wdata, 0);
        check_output("rst_mem_be", 32'(mem_be), 0);
        check_output("rst_if_rvalid", 32'(if_rvalid), 0);
        check_output("rst_d_rvalid", 32'(d_rvalid), 0);
        check_output("rst_if_rdata", if_rdata, 0);
        check_output("rst_d_rdata", d_rdata, 0);
        check_output("rst_err", 32'(err), 0);
      end else begin
        exp_ig = !m_busy && if_req && (!d_req || m_contested == STARVE_MAX);
        exp_dg = !m_busy && d_req && !exp_ig;
        check_output("m_if_gnt", 32'(if_gnt), 32'(exp_ig));
        check_output("m_d_gnt", 32'(d_gnt), 32'(exp_dg));
        check_output("m_mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) begin
          check_output("m_mem_addr", mem_addr, m_addr);
          check_output("m_mem_we", 32'(mem_we), 32'(m_we));
          check_output("m_mem_be", 32'(mem_be), 32'(m_be));
          if (m_we) check_output("m_mem_wdata", mem_wdata, m_wdata);
        end
        check_output("m_if_rvalid", 32'(if_rvalid), 32'(m_rv_i));
        check_output("m_d_rvalid", 32'(d_rvalid), 32'(m_rv_d));
        check_output("m_if_rdata", if_rdata, m_rdata_i);
        check_output("m_d_rdata", d_rdata, m_rdata_d);
        check_output("m_err", 32'(err), 32'(m_err));
        if (if_gnt) grant_seq = {grant_seq, "I"};
        if (d_gnt)  grant_seq = {grant_seq, "D"};

        m_rv_i = 0; m_rv_d = 0; m_err = 0;
        if (m_busy) begin
          if (mem_ack) begin
            m_busy = 0;
            if (!m_own_d) begin
              m_rdata_i = mem_rdata; m_rv_i = 1;
            end else begin
              if (!m_we) m_rdata_d = mem_rdata;
              m_rv_d = 1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
              m_busy = 0; m_err = 1;
              if (m_own_d) m_rv_d = 1; else m_rv_i = 1;
            end
          end
`endif
        end else if (exp_ig) begin
          m_busy = 1; m_own_d = 0; m_we = 0; m_addr = if_addr; m_be = 4'hF;
          m_contested = 0; m_wait = 0;
        end else if (exp_dg) begin
          m_busy = 1; m_own_d = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
          m_wait = 0;
          if (if_req && m_contested < STARVE_MAX) m_contested++;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stimulus
    string exp_seq;
    n_rst = 0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ack = 0; mem_rdata = 0;
    repeat (2) step();
    n_rst = 1;

    $display("[TB] single fetch");
    apply_stimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_output("fetch_gnt", 32'(if_gnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
    @(negedge clk);
    check_output("fetch_mem_req", 32'(mem_req), 1);
    check_output("fetch_mem_addr", mem_addr, 32'h100);
    check_output("fetch_mem_we", 32'(mem_we), 0);
    check_output("fetch_mem_be", 32'(mem_be), 32'hF);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("fetch_rvalid", 32'(if_rvalid), 1);
    check_output("fetch_rdata", if_rdata, 32'h00500093);

    $display("[TB] starvation order");
    step(); n_rst = 0;
    step(); n_rst = 1;
    grant_seq = "";
    apply_stimulus(1, 32'h1000, 1, 0, 32'h2000, 0, 4'hF, 1, 32'h12345678);
    repeat (19) step();
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp_seq = "DDDDIDDDDI";
    check_output("order_len", 32'(grant_seq.len()), 10);
    for (int i = 0; i < 10; i++)
      if (i < grant_seq.len())
        check_output($sformatf("order_%0d", i), 32'(grant_seq[i]), 32'(exp_seq[i]));

    $display("[TB] store with 3-cycle memory");
    apply_stimulus(0, 0, 1, 1, 32'h200, 32'hCAFEF00D, 4'h3, 0, 0);
    @(negedge clk); check_output("store_gnt", 32'(d_gnt), 1);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 0, 0, (i == 2), 32'h55555555);
      @(negedge clk);
      check_output("store_mem_req", 32'(mem_req), 1);
      check_output("store_mem_addr", mem_addr, 32'h200);
      check_output("store_mem_wdata", mem_wdata, 32'hCAFEF00D);
      check_output("store_mem_be", 32'(mem_be), 32'h3);
      check_output("store_mem_we", 32'(mem_we), 1);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("store_rvalid", 32'(d_rvalid), 1);
    check_output("store_rdata_kept", d_rdata, 32'h12345678);
    check_output("store_mem_req_low", 32'(mem_req), 0);

    $display("[TB] reset mid-transaction");
    apply_stimulus(0, 0, 1, 0, 32'h400, 0, 4'hF, 0, 0);
    @(negedge clk); check_output("rstmid_gnt", 32'(d_gnt), 1);
    step(); n_rst = 0; d_req = 0;
    @(negedge clk);
    check_output("rstmid_mem_req", 32'(mem_req), 0);
    step();
    step(); n_rst = 1; mem_ack = 1;
    @(negedge clk); check_output("rstmid_no_rvalid0", 32'(d_rvalid), 0);
    step();
    @(negedge clk); check_output("rstmid_no_rvalid1", 32'(d_rvalid), 0);
    apply_stimulus(1, 32'h300, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_output("rstmid_fetch_gnt", 32'(if_gnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD0001);
    @(negedge clk); check_output("rstmid_fetch_addr", mem_addr, 32'h300);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("rstmid_fetch_rvalid", 32'(if_rvalid), 1);
    check_output("rstmid_fetch_rdata", if_rdata, 32'hABCD0001);

    $display("[TB] stray ack in idle");
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("stray_if_rvalid", 32'(if_rvalid), 0);
      check_output("stray_d_rvalid", 32'(d_rvalid), 0);
      check_output("stray_mem_req", 32'(mem_req), 0);
      step();
    end
    mem_ack = 0;
    apply_stimulus(1, 32'h600, 0, 0, 0, 0, 0, 1, 32'h11112222);
    @(negedge clk); check_output("stray_fetch_gnt", 32'(if_gnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h11112222);
    @(negedge clk); check_output("stray_fetch_addr", mem_addr, 32'h600);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_output("stray_fetch_rvalid", 32'(if_rvalid), 1);
    check_output("stray_fetch_rdata", if_rdata, 32'h11112222);

`ifdef ARB_TIMEOUT_EN
    $display("[TB] timeout abort");
    apply_stimulus(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_output("to_gnt", 32'(if_gnt), 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check_output($sformatf("to_mem_req_%0d", i), 32'(mem_req), 1);
      step();
    end
    @(negedge clk);
    check_output("to_mem_req_low", 32'(mem_req), 0);
    check_output("to_rvalid", 32'(if_rvalid), 1);
    check_output("to_err", 32'(err), 1);
    check_output("to_rdata_kept", if_rdata, 32'h11112222);
    step();
    @(negedge clk);
    check_output("to_err_pulse", 32'(err), 0);
    step(); mem_ack = 1; mem_rdata = 32'h77777777;
    @(negedge clk);
    step(); mem_ack = 0;
    @(negedge clk);
    check_output("to_late_ack_rvalid", 32'(if_rvalid), 0);
    check_output("to_late_ack_rdata", if_rdata, 32'h11112222);
`endif

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter sharing a single unified memory port between the instruction-fetch requester and the load/store requester of the RV32 core. It accepts at most one outstanding transaction at a time. Data requests have fixed priority, and a starvation counter guarantees fetch progress. Each requester receives a grant on acceptance and a one-cycle response pulse on completion. It sits between the fetch/execute stages and the memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8)
- STARVE_MAX, 4, consecutive contested data grants before fetch is forced (≥1)
- TIMEOUT, 16, cycles without mem_ack before abort (used only with ARB_TIMEOUT_EN)

- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous reset, active low
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch complete, one-cycle pulse
- if_rdata  out  DATA_W  fetched word, valid with if_rvalid
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data complete, one-cycle pulse (loads and stores)
- d_rdata  out  DATA_W  load data, valid with d_rvalid for loads
- mem_req  out  1  memory request, held until mem_ack
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched request fields
- mem_ack  in  1  memory completion; sampled only in BUSY
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- err  out  1  timeout abort pulse (constant 0 without ARB_TIMEOUT_EN)

## Operation
- States:
  - IDLE: grants at most one request.
  - BUSY_I / BUSY_D: mem_req=1, waiting for mem_ack.
- Grant in IDLE: data wins, except fetch wins when if_req=1 and starve_cnt==STARVE_MAX. Only one of if_gnt/d_gnt per cycle. Both are 0 outside IDLE and while n_rst=0.
- On a grant, latch the request fields into the mem_* registers and the owner into state (BUSY_I or BUSY_D). Fetch grants drive mem_we=0 and mem_be=all ones.
- starve_cnt:
  - increments (saturating at STARVE_MAX) on a d_gnt issued while if_req=1;
  - cleared on if_gnt;
  - unchanged otherwise.
- In BUSY, on mem_ack:
  - go to IDLE and clear mem_req;
  - capture mem_rdata into the owner's rdata register (loads and fetches only; d_rdata holds its value for stores);
  - pulse the owner's rvalid in the next cycle.
- mem_ack in IDLE is ignored.
- Reset (any time, including mid-transaction):
  - state=IDLE, starve_cnt=0;
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rvalid, d_rvalid, if_rdata, d_rdata, err all 0.
  - The in-flight transaction is dropped with no response.

## Timing
- Grant cycle t (IDLE). mem_req is high from t+1 until the mem_ack cycle k (k ≥ t+1).
- Response pulse at k+1. State is IDLE at k+1, so a new grant is possible in the same cycle as the rvalid pulse.
- Minimum grant-to-rvalid latency is 2 cycles. Peak throughput is one transaction per 2 cycles.
- The mem_* outputs are registered and stable for the entire BUSY period.

## Configuration
- ARB_TIMEOUT_EN defined:
  - a counter clears on entry to BUSY and increments each BUSY cycle with mem_ack=0;
  - when it reaches TIMEOUT: state goes to IDLE, mem_req drops, and the next cycle pulses the owner's rvalid together with err=1;
  - the owner's rdata is unchanged;
  - a late mem_ack is ignored.
- ARB_TIMEOUT_EN undefined: no counter; the arbiter waits indefinitely; err is tied 0.

## Test plan
- Single fetch: if_req, if_addr=0x100 at t; mem_ack with mem_rdata=0x00500093 at t+1. Expect if_gnt at t, mem_addr=0x100 with mem_we=0 at t+1, if_rvalid with if_rdata=0x00500093 at t+2.
- Simultaneous requests, STARVE_MAX=4, both held continuously with zero-wait memory. Expect grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- Store: d_we=1, d_addr=0x200, d_wdata=0xCAFEF00D, d_be=0x3, 3-cycle memory delay. Expect mem_* held 3 cycles; d_rvalid one cycle after mem_ack; d_rdata unchanged.
- Reset mid-transaction: assert n_rst low in BUSY_D. Expect mem_req=0 immediately; no d_rvalid after release; next if_req is granted normally.
- Stray mem_ack=1 in IDLE with no requests. Expect no rvalid, no state change.
- ARB_TIMEOUT_EN, TIMEOUT=16, mem_ack never asserted. Expect mem_req high for 16 cycles, then if_rvalid=1 and err=1 for one cycle; a mem_ack 2 cycles later is ignored.
